// File: rtl/smart_defs_pkg.sv
// Shared SMART definitions: controller state encodings, default timing
// parameters and a helper for sizing the sequencing timer.
package smart_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int DEF_RST_CYCLES     = 4;
    localparam int DEF_HOLDOFF_CYCLES = 8;

    // Timer bits needed to hold the larger of the two reload values,
    // never fewer than one bit.
    function automatic int timer_width(input int rst_cycles, input int holdoff_cycles);
        int m;
        m = (rst_cycles > holdoff_cycles) ? rst_cycles : holdoff_cycles;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/smart_viol_log.sv
// Violation logger: rising-edge detect on the violation level, sticky
// first-violation capture of data address and PC, saturating event count.
// Ports:
//   mclk, reset            clock, synchronous active-high reset
//   viol_i                 violation level
//   mem_addr, ins_addr     addresses presented in the violating cycle
//   clr_status             one-cycle clear of all status
//   viol_evt               combinational rising-edge event
//   viol_flag/addr/pc/cnt  status outputs
module smart_viol_log #(
    parameter int SIZE_MEM_ADDR = 15,
    parameter int CNT_W         = 8
) (
    input  logic                     mclk,
    input  logic                     reset,
    input  logic                     viol_i,
    input  logic [SIZE_MEM_ADDR:0]   mem_addr,
    input  logic [15:0]              ins_addr,
    input  logic                     clr_status,
    output logic                     viol_evt,
    output logic                     viol_flag,
    output logic [SIZE_MEM_ADDR:0]   viol_addr,
    output logic [15:0]              viol_pc,
    output logic [CNT_W-1:0]         viol_cnt
);

    logic viol_q;

    assign viol_evt = viol_i & ~viol_q;

    always_ff @(posedge mclk) begin
        if (reset) begin
            viol_q    <= 1'b0;
            viol_flag <= 1'b0;
            viol_addr <= '0;
            viol_pc   <= '0;
            viol_cnt  <= '0;
        end else begin
            viol_q <= viol_i;
            if (viol_evt) begin
                // A coincident clear restarts the log with this event.
                if (clr_status)
                    viol_cnt <= CNT_W'(1);
                else if (viol_cnt != '1)
                    viol_cnt <= viol_cnt + CNT_W'(1);
                if (!viol_flag || clr_status) begin
                    viol_addr <= mem_addr;
                    viol_pc   <= ins_addr;
                    viol_flag <= 1'b1;
                end
            end else if (clr_status) begin
                viol_flag <= 1'b0;
                viol_addr <= '0;
                viol_pc   <= '0;
                viol_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/smart_viol_ctrl.sv
// SMART violation controller: converts each violation event into a
// fixed-length registered system-reset request followed by a hold-off
// window, and logs violations through smart_viol_log.
// Ports:
//   mclk, reset            clock, synchronous active-high power-on reset
//   viol_i                 violation level from the access controller
//   mem_addr, ins_addr     addresses presented in the violating cycle
//   disable_debug          log only, never request reset
//   clr_status             one-cycle clear of status registers
//   sys_rst_req            registered reset request
//   viol_flag/addr/pc/cnt  sticky status
//   busy                   high in ASSERT or HOLDOFF
//
// state   | meaning
// IDLE    | waiting for a violation event
// ASSERT  | sys_rst_req high, timer counts RST_CYCLES
// HOLDOFF | request released, new events logged only
module smart_viol_ctrl
    import smart_defs::*;
#(
    parameter int SIZE_MEM_ADDR  = 15,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic                     mclk,
    input  logic                     reset,
    input  logic                     viol_i,
    input  logic [SIZE_MEM_ADDR:0]   mem_addr,
    input  logic [15:0]              ins_addr,
    input  logic                     disable_debug,
    input  logic                     clr_status,
    output logic                     sys_rst_req,
    output logic                     viol_flag,
    output logic [SIZE_MEM_ADDR:0]   viol_addr,
    output logic [15:0]              viol_pc,
    output logic [CNT_W-1:0]         viol_cnt,
    output logic                     busy
);

    localparam int TW = timer_width(RST_CYCLES, HOLDOFF_CYCLES);
    localparam logic [TW-1:0] RST_LOAD  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? TW'(HOLDOFF_CYCLES - 1) : '0;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          viol_evt;
    logic          rst_req_nxt, busy_nxt;

    smart_viol_log #(
        .SIZE_MEM_ADDR (SIZE_MEM_ADDR),
        .CNT_W         (CNT_W)
    ) u_log (
        .mclk       (mclk),
        .reset      (reset),
        .viol_i     (viol_i),
        .mem_addr   (mem_addr),
        .ins_addr   (ins_addr),
        .clr_status (clr_status),
        .viol_evt   (viol_evt),
        .viol_flag  (viol_flag),
        .viol_addr  (viol_addr),
        .viol_pc    (viol_pc),
        .viol_cnt   (viol_cnt)
    );

    // Outputs are registered from the next state so they line up with the
    // state register and carry no decode glitches into the reset generator.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            sys_rst_req <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            sys_rst_req <= rst_req_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            ST_IDLE: begin
                if (viol_evt && !disable_debug) begin
                    state_nxt = ST_ASSERT;
                    timer_nxt = RST_LOAD;
                end
            end
            ST_ASSERT: begin
                if (timer == '0) begin
                    if (HOLDOFF_CYCLES > 0) begin
                        state_nxt = ST_HOLDOFF;
                        timer_nxt = HOLD_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (timer == '0)
                    state_nxt = ST_IDLE;
                else
                    timer_nxt = timer - TW'(1);
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        rst_req_nxt = (state_nxt == ST_ASSERT);
        busy_nxt    = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_smart_viol_ctrl.sv
module tb_smart_viol_ctrl;

    typedef struct {
        logic        rst_in;
        logic        viol;
        logic        dis;
        logic        clr;
        logic [15:0] maddr;
        logic [15:0] iaddr;
        logic        e_rst;
        logic        e_busy;
        logic        e_flag;
        logic [15:0] e_addr;
        logic [15:0] e_pc;
        logic [7:0]  e_cnt;
    } vec_t;

    logic        mclk = 1'b0;
    logic        reset, viol_i, disable_debug, clr_status;
    logic [15:0] mem_addr, ins_addr;
    logic        sys_rst_req, viol_flag, busy;
    logic [15:0] viol_addr, viol_pc;
    logic [7:0]  viol_cnt;

    logic        viol_s;
    logic        s_rst, s_flag, s_busy;
    logic [15:0] s_addr, s_pc;
    logic [1:0]  s_cnt;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 mclk = ~mclk;

    smart_viol_ctrl dut (
        .mclk          (mclk),
        .reset         (reset),
        .viol_i        (viol_i),
        .mem_addr      (mem_addr),
        .ins_addr      (ins_addr),
        .disable_debug (disable_debug),
        .clr_status    (clr_status),
        .sys_rst_req   (sys_rst_req),
        .viol_flag     (viol_flag),
        .viol_addr     (viol_addr),
        .viol_pc       (viol_pc),
        .viol_cnt      (viol_cnt),
        .busy          (busy)
    );

    smart_viol_ctrl #(.CNT_W(2)) u_sat (
        .mclk          (mclk),
        .reset         (reset),
        .viol_i        (viol_s),
        .mem_addr      (mem_addr),
        .ins_addr      (ins_addr),
        .disable_debug (1'b1),
        .clr_status    (clr_status),
        .sys_rst_req   (s_rst),
        .viol_flag     (s_flag),
        .viol_addr     (s_addr),
        .viol_pc       (s_pc),
        .viol_cnt      (s_cnt),
        .busy          (s_busy)
    );

    function automatic vec_t mk(input logic r, input logic v, input logic d, input logic c,
                                input logic [15:0] ma, input logic [15:0] ia,
                                input logic er, input logic eb, input logic ef,
                                input logic [15:0] ea, input logic [15:0] ep,
                                input logic [7:0] ec);
        vec_t t;
        t.rst_in = r; t.viol = v; t.dis = d; t.clr = c;
        t.maddr = ma; t.iaddr = ia;
        t.e_rst = er; t.e_busy = eb; t.e_flag = ef;
        t.e_addr = ea; t.e_pc = ep; t.e_cnt = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vecs(input string tag);
        vec_t e;
        foreach (vecs[i]) begin
            reset         = vecs[i].rst_in;
            viol_i        = vecs[i].viol;
            disable_debug = vecs[i].dis;
            clr_status    = vecs[i].clr;
            mem_addr      = vecs[i].maddr;
            ins_addr      = vecs[i].iaddr;
            exp_q.push_back(vecs[i]);
            @(posedge mclk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d].sys_rst_req", tag, i), sys_rst_req, e.e_rst);
            check($sformatf("%s[%0d].busy", tag, i), busy, e.e_busy);
            check($sformatf("%s[%0d].viol_flag", tag, i), viol_flag, e.e_flag);
            check($sformatf("%s[%0d].viol_addr", tag, i), viol_addr, e.e_addr);
            check($sformatf("%s[%0d].viol_pc", tag, i), viol_pc, e.e_pc);
            check($sformatf("%s[%0d].viol_cnt", tag, i), viol_cnt, e.e_cnt);
        end
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1; viol_i = 1'b0; disable_debug = 1'b0; clr_status = 1'b0;
        mem_addr = '0; ins_addr = '0; viol_s = 1'b0;

        // Reset state
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 8'd0));
        run_vecs("reset");

        // Single pulse, then a second rising edge inside HOLDOFF at k=6
        for (int k = 0; k < 14; k++)
            vecs.push_back(mk(0, (k == 0 || k == 6), 0, 0,
                              (k == 6) ? 16'h00D0 : 16'h00C8,
                              (k == 6) ? 16'h4100 : 16'h4000,
                              (k < 4), (k < 12), 1, 16'h00C8, 16'h4000,
                              (k >= 6) ? 8'd2 : 8'd1));
        // clr_status alone
        vecs.push_back(mk(0, 0, 0, 1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 8'd0));
        run_vecs("pulse");

        // Level held high 20 cycles: one pulse, no retrigger back in IDLE
        for (int k = 0; k < 23; k++)
            vecs.push_back(mk(0, (k < 20), 0, 0, 16'h0042, 16'h1234,
                              (k < 4), (k < 12), 1, 16'h0042, 16'h1234, 8'd1));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 8'd0));
        run_vecs("held");

        // disable_debug: three events, logging only
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, (k % 2 == 0), 1, 0,
                              16'(16 * (k / 2 + 1)), 16'(16'h5000 + k),
                              0, 0, 1, 16'h0010, 16'h5000, 8'(k / 2 + 1)));
        // clear coincident with an event: event wins
        vecs.push_back(mk(0, 1, 1, 1, 16'h0100, 16'h6000, 0, 0, 1, 16'h0100, 16'h6000, 8'd1));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 8'd0));
        run_vecs("nodbg");

        // disable_debug raised during ASSERT does not shorten the pulse
        for (int k = 0; k < 13; k++)
            vecs.push_back(mk(0, (k == 0), (k >= 1), 0, 16'h0200, 16'h7000,
                              (k < 4), (k < 12), 1, 16'h0200, 16'h7000, 8'd1));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 8'd0));
        run_vecs("dislate");

        // Reset mid-ASSERT, then a fresh edge triggers again from IDLE
        vecs.push_back(mk(0, 1, 0, 0, 16'h0300, 16'h7100, 1, 1, 1, 16'h0300, 16'h7100, 8'd1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0300, 16'h7100, 1, 1, 1, 16'h0300, 16'h7100, 8'd1));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0300, 16'h7100, 0, 0, 0, 16'h0, 16'h0, 8'd0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0300, 16'h7100, 0, 0, 0, 16'h0, 16'h0, 8'd0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0310, 16'h7110, 1, 1, 1, 16'h0310, 16'h7110, 8'd1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0310, 16'h7110, 1, 1, 1, 16'h0310, 16'h7110, 8'd1));
        run_vecs("midrst");

        // Saturation on the CNT_W=2 instance
        reset = 1'b0; clr_status = 1'b0; viol_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            viol_s = 1'b1;
            @(posedge mclk);
            #1;
            check($sformatf("sat[%0d].viol_cnt", i), s_cnt, (i + 1 > 3) ? 3 : i + 1);
            check($sformatf("sat[%0d].sys_rst_req", i), s_rst, 0);
            check($sformatf("sat[%0d].busy", i), s_busy, 0);
            viol_s = 1'b0;
            @(posedge mclk);
            #1;
        end
        check("sat.viol_flag", s_flag, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smart_viol_ctrl.md
Name: smart_viol_ctrl

Overview:
Downstream consumer of the SMART memory-access controller's violation indication. It turns each violation into a fixed-length, registered system-reset request, then enforces a hold-off window. It also logs the first offending data address and PC in sticky status registers and keeps a saturating violation count. It sits between the access controller and the MCU reset/clock module. Its status outputs stay valid through the system reset it requests.

Parameters:
SIZE_MEM_ADDR, 15, MSB index of the address buses (buses are SIZE_MEM_ADDR+1 bits wide)
RST_CYCLES, 4, cycles sys_rst_req is held high per accepted violation (>=1)
HOLDOFF_CYCLES, 8, cycles after reset release during which new violations are not acted on (>=0)
CNT_W, 8, width of the saturating violation counter

Ports:
mclk  in  1  system clock; everything is on the rising edge
reset  in  1  synchronous, active-high reset; power-on domain only, never driven from sys_rst_req
viol_i  in  1  violation level from the access controller (in_safe_area)
mem_addr  in  SIZE_MEM_ADDR+1  data address presented in the violating cycle
ins_addr  in  16  instruction address presented in the violating cycle
disable_debug  in  1  high: log violations but never request reset
clr_status  in  1  one-cycle pulse; clears viol_flag, viol_addr, viol_pc, viol_cnt
sys_rst_req  out  1  registered system-reset request to the reset generator
viol_flag  out  1  sticky: at least one violation seen since last clear
viol_addr  out  SIZE_MEM_ADDR+1  mem_addr captured at first violation
viol_pc  out  16  ins_addr captured at first violation
viol_cnt  out  CNT_W  saturating count of violation events
busy  out  1  high in ASSERT or HOLDOFF

Behaviour:
- Reset (reset=1): state IDLE; sys_rst_req=0, viol_flag=0, viol_addr=0, viol_pc=0, viol_cnt=0, busy=0, internal viol_q=0, timer=0.
- Event detection: viol_q registers viol_i every cycle. event = viol_i & ~viol_q. A level held high for N cycles is one event.
- Logging happens on every event, in any state, regardless of disable_debug:
  - viol_cnt increments by 1 and saturates at 2^CNT_W-1.
  - If viol_flag==0, or clr_status is high in the same cycle: viol_addr<=mem_addr, viol_pc<=ins_addr, viol_flag<=1.
  - Otherwise viol_addr and viol_pc hold their values (first-violation capture).
- clr_status alone clears flag, addr, pc and cnt to 0. If clr_status and an event coincide, the event wins: flag=1, addr and pc take the new values, cnt=1.
- FSM:
  - IDLE: on event & ~disable_debug, go to ASSERT and set timer=RST_CYCLES-1. Otherwise stay.
  - ASSERT: sys_rst_req=1. Decrement timer each cycle. When timer==0: if HOLDOFF_CYCLES>0, go to HOLDOFF with timer=HOLDOFF_CYCLES-1; else go to IDLE.
  - HOLDOFF: sys_rst_req=0. Decrement timer; go to IDLE when timer==0. Events here are logged only and do not retrigger.
- Latency: event in cycle T gives sys_rst_req=1 in cycles T+1 through T+RST_CYCLES. busy follows the same window and extends through HOLDOFF.
- disable_debug is sampled only in IDLE at the event. Raising it during ASSERT does not shorten the pulse.
- A violation level that is still high when the FSM returns to IDLE does not retrigger; a new rising edge is required.
- Timer width is clog2(max(RST_CYCLES,HOLDOFF_CYCLES,2)) bits; arithmetic is unsigned with no wrap (decrement only while nonzero).
- Reset mid-ASSERT or mid-HOLDOFF: immediate return to IDLE with all outputs zero on the next edge.

Decomposition:
- Shared package/include smart_defs: state encodings (IDLE=2'd0, ASSERT=2'd1, HOLDOFF=2'd2) and default RST_CYCLES/HOLDOFF_CYCLES, reused by the rest of the SMART blocks.
- Sub-module smart_viol_log: edge detect, capture registers and saturating counter.
- FSM and timer stay in the top module.

Test Plan:
- After reset, viol_i pulse 1 cycle at T with mem_addr=16'h00C8, ins_addr=16'h4000, disable_debug=0 -> sys_rst_req high T+1..T+4, busy high T+1..T+12, viol_flag=1, viol_addr=00C8, viol_pc=4000, viol_cnt=1.
- viol_i held high 20 cycles -> exactly one reset pulse of 4 cycles, viol_cnt=1, no retrigger after HOLDOFF.
- Second rising edge during HOLDOFF with mem_addr=16'h00D0 -> no new sys_rst_req, viol_cnt=2, viol_addr stays 00C8.
- disable_debug=1, three separate events -> sys_rst_req never high, busy stays 0, viol_cnt=3, first-event addr and pc captured.
- clr_status coincident with event (mem_addr=16'h0100) -> viol_flag=1, viol_addr=0100, viol_cnt=1. clr_status alone later -> all status outputs 0.
- CNT_W=2, 5 events with disable_debug=1 -> viol_cnt saturates at 3. Assert reset during ASSERT -> sys_rst_req=0 on the next edge, state IDLE.
